// File: rtl/display_spi_arb_pkg.sv
// Shared types and pin-level constants for the display SPI bus arbiter.
// Imported by the arbiter top and any block that decodes dbg_state.
package display_spi_arb_pkg;

  // The numeric values are visible on dbg_state, so they must not be reordered.
  typedef enum logic [2:0] {
    StCtrlIdle    = 3'd0,
    StCtrlStart   = 3'd1,
    StCtrlBusy    = 3'd2,
    StGuardToHost = 3'd3,
    StHost        = 3'd4,
    StGuardToCtrl = 3'd5
  } arb_state_e;

  localparam int unsigned GuardCntWidth = 8;

  typedef struct packed {
    logic mosi;
    logic sck;
    logic cs;
    logic dc;
  } spi_pins_t;

  // The panel is held deselected and quiet while ownership changes hands.
  localparam logic GuardMosi = 1'b0;
  localparam logic GuardSck  = 1'b0;
  localparam logic GuardCs   = 1'b1;
  localparam logic GuardDc   = 1'b1;

  localparam spi_pins_t GuardPins = '{
    mosi: GuardMosi,
    sck:  GuardSck,
    cs:   GuardCs,
    dc:   GuardDc
  };

  // The controller only streams pixel data, so it keeps the panel selected in data mode.
  localparam logic CtrlCs = 1'b0;
  localparam logic CtrlDc = 1'b1;

  function automatic logic is_guard_state(arb_state_e s);
    return (s == StGuardToHost) || (s == StGuardToCtrl);
  endfunction

  function automatic logic is_ctrl_state(arb_state_e s);
    return (s == StCtrlIdle) || (s == StCtrlStart) || (s == StCtrlBusy);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for asynchronous level inputs.
// Resets to all-zero; Depth must be at least 2.
module sync_ff #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Depth-1:0][Width-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[Depth-2:0], d};
    end
  end

  assign q = stage_q[Depth-1];

endmodule

// File: rtl/display_spi_arbiter.sv
// Shares the display SPI bus between the host bypass and the framebuffer controller,
// switching ownership only between frames with an idle guard interval.
module display_spi_arbiter
  import display_spi_arb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic       aclk,
  input  logic       resetn,

  input  logic       host_req,
  input  logic       host_mosi,
  input  logic       host_sck,
  input  logic       host_cs,
  input  logic       host_dc,

  input  logic       ctrl_mosi,
  input  logic       ctrl_sck,
  input  logic       ctrl_transfer_running,
  output logic       ctrl_start_transfer,

  input  logic       frame_pending,

  output logic       display_mosi,
  output logic       display_sck,
  output logic       display_cs,
  output logic       display_dc,

  output logic       host_grant,
  output logic [2:0] dbg_state
);

  localparam logic [GuardCntWidth-1:0] GuardLoad = GuardCntWidth'(GUARD_CYCLES - 1);
  localparam logic [GuardCntWidth-1:0] CntOne    = GuardCntWidth'(1);

  logic host_req_s;

  sync_ff #(
    .Depth (SYNC_STAGES),
    .Width (1)
  ) u_host_req_sync (
    .clk   (aclk),
    .rst_n (resetn),
    .d     (host_req),
    .q     (host_req_s)
  );

  arb_state_e               state_q, state_d;
  logic [GuardCntWidth-1:0] cnt_q, cnt_d;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StCtrlIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StCtrlIdle: begin
        // Host takes priority over a pending frame.
        if (host_req_s) begin
          state_d = StGuardToHost;
          cnt_d   = GuardLoad;
        end else if (frame_pending) begin
          state_d = StCtrlStart;
        end
      end
      StCtrlStart: begin
        if (ctrl_transfer_running) begin
          state_d = StCtrlBusy;
        end
      end
      StCtrlBusy: begin
        // A host request arriving now waits until the frame is fully out.
        if (!ctrl_transfer_running) begin
          state_d = StCtrlIdle;
        end
      end
      StGuardToHost: begin
        if (cnt_q == '0) begin
          state_d = StHost;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHost: begin
        if (!host_req_s) begin
          state_d = StGuardToCtrl;
          cnt_d   = GuardLoad;
        end
      end
      StGuardToCtrl: begin
        if (cnt_q == '0) begin
          state_d = StCtrlIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StCtrlIdle;
        cnt_d   = '0;
      end
    endcase
  end

  spi_pins_t pins;

  always_comb begin
    pins                = '{mosi: ctrl_mosi, sck: ctrl_sck, cs: CtrlCs, dc: CtrlDc};
    ctrl_start_transfer = 1'b0;
    host_grant          = 1'b0;
    unique case (state_q)
      StCtrlIdle, StCtrlBusy: begin
        pins = '{mosi: ctrl_mosi, sck: ctrl_sck, cs: CtrlCs, dc: CtrlDc};
      end
      StCtrlStart: begin
        ctrl_start_transfer = 1'b1;
      end
      StGuardToHost, StGuardToCtrl: begin
        pins = GuardPins;
      end
      StHost: begin
        // Host pins pass straight through; they are asynchronous to aclk.
        pins       = '{mosi: host_mosi, sck: host_sck, cs: host_cs, dc: host_dc};
        host_grant = 1'b1;
      end
      default: begin
        pins = GuardPins;
      end
    endcase
  end

  assign display_mosi = pins.mosi;
  assign display_sck  = pins.sck;
  assign display_cs   = pins.cs;
  assign display_dc   = pins.dc;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_display_spi_arbiter.sv
// Bench for display_spi_arbiter: ownership model checked every cycle plus
// directed latency and reset checks with hand-computed values.
module tb_display_spi_arbiter;

  localparam int unsigned SyncStages  = 2;
  localparam int unsigned GuardCycles = 4;

  logic       aclk = 1'b0;
  logic       resetn = 1'b0;
  logic       host_req = 1'b0;
  logic       host_mosi = 1'b0;
  logic       host_sck = 1'b0;
  logic       host_cs = 1'b0;
  logic       host_dc = 1'b0;
  logic       ctrl_mosi = 1'b0;
  logic       ctrl_sck = 1'b0;
  logic       ctrl_transfer_running = 1'b0;
  logic       frame_pending = 1'b0;
  logic       ctrl_start_transfer;
  logic       display_mosi;
  logic       display_sck;
  logic       display_cs;
  logic       display_dc;
  logic       host_grant;
  logic [2:0] dbg_state;

  display_spi_arbiter #(
    .SYNC_STAGES  (SyncStages),
    .GUARD_CYCLES (GuardCycles)
  ) dut (
    .aclk                  (aclk),
    .resetn                (resetn),
    .host_req              (host_req),
    .host_mosi             (host_mosi),
    .host_sck              (host_sck),
    .host_cs               (host_cs),
    .host_dc               (host_dc),
    .ctrl_mosi             (ctrl_mosi),
    .ctrl_sck              (ctrl_sck),
    .ctrl_transfer_running (ctrl_transfer_running),
    .ctrl_start_transfer   (ctrl_start_transfer),
    .frame_pending         (frame_pending),
    .display_mosi          (display_mosi),
    .display_sck           (display_sck),
    .display_cs            (display_cs),
    .display_dc            (display_dc),
    .host_grant            (host_grant),
    .dbg_state             (dbg_state)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner plus remaining guard cycles, host request seen after the sync delay.
  int                    m_state = 0;
  int                    m_left  = 0;
  logic [SyncStages-1:0] m_hist  = '0;
  logic                  m_hs;

  assign m_hs = m_hist[SyncStages-1];

  always @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_state <= 0;
      m_left  <= 0;
      m_hist  <= '0;
    end else begin
      case (m_state)
        0: begin
          if (m_hs) begin
            m_state <= 3;
            m_left  <= GuardCycles;
          end else if (frame_pending) begin
            m_state <= 1;
          end
        end
        1: if (ctrl_transfer_running) m_state <= 2;
        2: if (!ctrl_transfer_running) m_state <= 0;
        3, 5: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_state <= (m_state == 3) ? 4 : 0;
        end
        4: begin
          if (!m_hs) begin
            m_state <= 5;
            m_left  <= GuardCycles;
          end
        end
        default: m_state <= 0;
      endcase
      m_hist <= {m_hist[SyncStages-2:0], host_req};
    end
  end

  // {dbg_state, grant, start, mosi, sck, cs, dc}
  function automatic logic [8:0] model_out();
    logic [3:0] p;
    case (m_state)
      4:       p = {host_mosi, host_sck, host_cs, host_dc};
      3, 5:    p = 4'b0011;
      default: p = {ctrl_mosi, ctrl_sck, 1'b0, 1'b1};
    endcase
    return {3'(m_state), m_state == 4, m_state == 1, p};
  endfunction

  always @(negedge aclk) begin
    if (cmp_en) begin
      check("cycle", {7'b0, dbg_state, host_grant, ctrl_start_transfer, display_mosi,
                      display_sck, display_cs, display_dc}, {7'b0, model_out()});
    end
  end

  // Random data on pins whose value only matters through the mux.
  always @(posedge aclk) begin
    #2;
    ctrl_mosi = 1'($urandom);
    ctrl_sck  = 1'($urandom);
    host_mosi = 1'($urandom);
    host_cs   = 1'($urandom);
    host_dc   = 1'($urandom);
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic count_until_grant(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (host_grant === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic count_until_dbg(input logic [2:0] v, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (dbg_state === v) begin
        n = i;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c3, c4, c5;

    repeat (3) @(posedge aclk);
    #1;
    resetn = 1'b1;
    cmp_en = 1'b1;
    @(negedge aclk);
    check("reset_dbg",   {13'b0, dbg_state}, 16'd0);
    check("reset_flags", {14'b0, host_grant, ctrl_start_transfer}, 16'd0);
    check("reset_cs_dc", {14'b0, display_cs, display_dc}, 16'b01);
    #1;

    // Controller frame: start the cycle after frame_pending, drops after running seen.
    step();
    frame_pending = 1'b1;
    @(negedge aclk);
    check("start_before_edge", {15'b0, ctrl_start_transfer}, 16'd0);
    step();
    frame_pending = 1'b0;
    @(negedge aclk);
    check("start_asserted", {15'b0, ctrl_start_transfer}, 16'd1);
    repeat (2) step();
    ctrl_transfer_running = 1'b1;
    step();
    @(negedge aclk);
    check("start_dropped", {15'b0, ctrl_start_transfer}, 16'd0);
    check("busy_state", {13'b0, dbg_state}, 16'd2);
    repeat (4) step();
    ctrl_transfer_running = 1'b0;
    step();
    @(negedge aclk);
    check("back_idle", {13'b0, dbg_state}, 16'd0);
    check("idle_cs", {15'b0, display_cs}, 16'd0);

    // Host request from idle: grant after sync + 1 + guard edges.
    step();
    host_req = 1'b1;
    count_until_grant(20, n);
    check("host_grant_latency", 16'(n), 16'd7);
    #1;
    host_sck = 1'b1;
    #1;
    check("host_sck_pass_hi", {15'b0, display_sck}, 16'd1);
    host_sck = 1'b0;
    #1;
    check("host_sck_pass_lo", {15'b0, display_sck}, 16'd0);
    step();
    host_req = 1'b0;
    count_until_dbg(3'd0, 20, n);
    check("ctrl_return_latency", 16'(n), 16'd7);
    #1;

    // Host request during a long controller transfer is deferred.
    step();
    frame_pending = 1'b1;
    step();
    frame_pending = 1'b0;
    ctrl_transfer_running = 1'b1;
    step();
    host_req = 1'b1;
    repeat (100) step();
    @(negedge aclk);
    check("busy_held", {13'b0, dbg_state}, 16'd2);
    step();
    ctrl_transfer_running = 1'b0;
    count_until_grant(20, n);
    check("deferred_grant", 16'(n), 16'd6);
    step();
    host_req = 1'b0;
    repeat (10) step();

    // Synchronised host request and frame_pending together: host wins.
    host_req = 1'b1;
    step();
    step();
    frame_pending = 1'b1;
    count_until_dbg(3'd3, 10, n);
    check("host_wins", 16'(n), 16'd1);
    check("host_wins_start", {15'b0, ctrl_start_transfer}, 16'd0);
    repeat (6) step();
    frame_pending = 1'b0;
    host_req = 1'b0;
    repeat (10) step();
    @(negedge aclk);
    check("after_tie_idle", {13'b0, dbg_state}, 16'd0);

    // Short host pulse: full guard, one host cycle, full guard back.
    step();
    host_req = 1'b1;
    repeat (3) step();
    host_req = 1'b0;
    c3 = 0;
    c4 = 0;
    c5 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (dbg_state == 3'd3) c3++;
      if (dbg_state == 3'd4) c4++;
      if (dbg_state == 3'd5) c5++;
      @(posedge aclk);
    end
    check("pulse_guard_to_host", 16'(c3), 16'd4);
    check("pulse_host_cycles", 16'(c4), 16'd1);
    check("pulse_guard_to_ctrl", 16'(c5), 16'd4);
    @(negedge aclk);
    check("pulse_end_idle", {13'b0, dbg_state}, 16'd0);

    // Asynchronous reset in the middle of HOST.
    step();
    host_req = 1'b1;
    count_until_grant(20, n);
    check("pre_reset_grant", 16'(n), 16'd7);
    @(posedge aclk);
    #3;
    resetn = 1'b0;
    #1;
    check("async_reset_grant", {15'b0, host_grant}, 16'd0);
    check("async_reset_cs", {15'b0, display_cs}, 16'd0);
    check("async_reset_dbg", {13'b0, dbg_state}, 16'd0);
    host_req = 1'b0;
    step();
    resetn = 1'b1;
    repeat (3) step();
    @(negedge aclk);
    check("post_reset_idle", {13'b0, dbg_state}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
